rob_commit: RTL and testbench
=============================

// Module: rob_commit
// PURPOSE
//  Reorder buffer: producer of the rename tags (nicks) and in-order commits consumed by regfile.
//  Allocates one entry per dispatched instruction and hands its nick to regfile for rd renaming.
//  Captures CDB results, retires the head in program order to regfile or LSB, and raises clr on branch mispredict.
//  Sits between dispatch/CDB and regfile/LSB/ifetch.
// PARAMETERS
//  ROB_DEPTH  16  entries; nick = slot index + 1, nick 0 reserved for "register holds committed value"
//  NICK_W     5   nick width, must satisfy 2^NICK_W > ROB_DEPTH
// PORTS
//  clk            in   1       clock
//  rst            in   1       reset, synchronous, active-high
//  rdy            in   1       global ready; low freezes all state
//  iDP_en         in   1       dispatch allocation request
//  iDP_rd_regnm   in   5       destination register
//  iDP_op         in   OpBus   decoded op (store/branch classification from config.v)
//  iDP_pc         in   32      instruction pc
//  iDP_pd         in   1       predicted taken
//  iDP_q1_nick    in   NICK_W  operand nick to look up (bypass)
//  iDP_q2_nick    in   NICK_W  operand nick to look up
//  oDP_full       out  1       no free entry; dispatch must stall
//  oDP_q1_rdy     out  1       q1 entry already has its result (comb)
//  oDP_q1_dt      out  32      q1 result data (comb)
//  oDP_q2_rdy     out  1       as q1
//  oDP_q2_dt      out  32      as q1
//  oRF_nick_en    out  1       rename write to regfile (comb, same cycle as accepted iDP_en)
//  oRF_nick_regnm out  5       renamed register
//  oRF_nick       out  NICK_W  allocated nick (tail+1)
//  iCDB_en        in   1       result broadcast
//  iCDB_nick      in   NICK_W  producing entry
//  iCDB_dt        in   32      result data (rd value; link address for jumps)
//  iCDB_tk        in   1       branch actual taken
//  iCDB_tgt       in   32      branch/jump correct next pc
//  oRF_en         out  1       commit write (registered, 1-cycle pulse)
//  oRF_rd_regnm   out  5       commit register
//  oRF_rd_dt      out  32      commit data
//  oRF_rd_nick    out  NICK_W  committed nick (regfile clears rename only if still equal)
//  oLSB_st_en     out  1       store commit pulse
//  oLSB_st_nick   out  NICK_W  committed store's nick
//  oCLR           out  1       flush pulse to regfile/RS/LSB/ifetch
//  oIF_pc         out  32      redirect pc, valid with oCLR
// BEHAVIOUR
//  - Reset: head=tail=count=0, all valid/ready bits 0; every output 0, oDP_full=0.
//  - Allocate when iDP_en & !oDP_full & !oCLR: entry[tail] <= {op,rd,pc,pd,ready=0}; tail wraps at ROB_DEPTH-1 -> 0.
//  - oRF_nick_en=1 only for accepted alloc with rd!=0 and op not store/branch.
//  - oDP_full = (count==ROB_DEPTH); iDP_en while full is ignored, no state change.
//  - CDB: iCDB_en writes dt/tk/tgt into entry[iCDB_nick-1], sets ready; nick 0 ignored.
//  - Bypass: oDP_qX_rdy=1 when qX_nick!=0 and entry ready; does not see same-cycle CDB (RS snoops CDB).
//  - Commit, 1 cycle after head becomes ready (no same-cycle CDB->commit path), one per cycle:
//    * normal op, rd!=0: oRF_en=1 with rd/dt/nick; rd==0: oRF_en=0, entry still retired.
//    * store: oLSB_st_en=1 with nick; oRF_en=0.
//    * branch: iCDB_tk!=pd -> oCLR=1, oIF_pc=tgt; jalr with mismatched target likewise, oRF_en also 1 same cycle.
//  - Alloc + commit same cycle: count unchanged, both pointers advance.
//  - oCLR cycle: next state head=tail=count=0, all ready cleared; same-cycle iDP_en and iCDB_en dropped.
//  - rdy=0: state frozen, oRF_en/oLSB_st_en/oCLR/oRF_nick_en forced 0.
//  - rst mid-operation overrides all; in-flight entries discarded.
// STRUCTURE
//  - config.v: NickBus, ROB_DEPTH, OpBus and op codes, is_store/is_branch classification macros.
//  - Entry storage as parallel reg arrays; pointer/count logic inline. No sub-module.
// TESTING
//  - Reset then dispatch ADDI x5 -> oRF_nick_en=1, regnm=5, nick=1; CDB nick1 dt=7 -> next cycle oRF_en, x5=7, nick=1.
//  - 16 allocs without CDB -> oDP_full=1; 17th iDP_en ignored; one commit -> full drops, tail wrapped to 0 -> nick 1.
//  - Results out of order: CDB nick3 then nick2 then nick1 -> commits strictly nick1,2,3 on consecutive cycles.
//  - BEQ pd=0, CDB tk=1 tgt=0x100 -> oCLR=1, oIF_pc=0x100; next cycle count=0, next alloc gets nick 1.
//  - SW with rd field 5 -> oRF_nick_en=0; commit gives oLSB_st_en=1, oRF_en=0.
//  - rdy=0 with ready head -> no commit; rdy=1 -> commit next cycle; bypass q1_nick=2 ready dt=9 -> q1_rdy=1, q1_dt=9.

Source files
------------

// File: rtl/rob_commit_pkg.sv
// ============================================================================
// Module  : rob_commit_pkg
// Purpose : Shared definitions for the reorder buffer. This file holds the
//           default depth and nick width, the decoded-op bus, the op codes,
//           and the store/branch/jalr classification helpers.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package rob_commit_pkg;

   localparam int ROB_DEPTH_DEF = 16;
   localparam int NICK_W_DEF    = 5;
   localparam int OP_W          = 5;
   localparam int REG_W         = 5;
   localparam int XLEN          = 32;

   typedef logic [OP_W-1:0] op_t;

   localparam op_t OP_NOP  = 5'd0;
   localparam op_t OP_JAL  = 5'd3;
   localparam op_t OP_JALR = 5'd4;
   localparam op_t OP_BEQ  = 5'd5;
   localparam op_t OP_BNE  = 5'd6;
   localparam op_t OP_BLT  = 5'd7;
   localparam op_t OP_BGE  = 5'd8;
   localparam op_t OP_BLTU = 5'd9;
   localparam op_t OP_BGEU = 5'd10;
   localparam op_t OP_LW   = 5'd11;
   localparam op_t OP_SB   = 5'd12;
   localparam op_t OP_SH   = 5'd13;
   localparam op_t OP_SW   = 5'd14;
   localparam op_t OP_ADDI = 5'd15;
   localparam op_t OP_ADD  = 5'd16;

   function automatic logic is_store(input op_t op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   // Conditional branches only; jal/jalr write rd and are handled as normal ops.
   function automatic logic is_branch(input op_t op);
      return (op >= OP_BEQ) && (op <= OP_BGEU);
   endfunction

   function automatic logic is_jalr(input op_t op);
      return op == OP_JALR;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rob_commit.sv
// ============================================================================
// Module  : rob_commit
// Purpose : Reorder buffer. Allocates one entry per dispatched instruction
//           and hands its nick (slot+1) to the regfile for renaming. It
//           captures CDB results and retires the head in program order to
//           the regfile or LSB. It flushes everything on a mispredict.
// Ports   : clk/rst/rdy     clock, sync active-high reset, global stall
//           iDP_* / oDP_*   dispatch allocation, full flag, operand bypass
//           oRF_nick*       rename write (comb, same cycle as allocation)
//           iCDB_*          result broadcast
//           oRF_en/rd_*     registered commit write
//           oLSB_st_*       registered store commit pulse
//           oCLR / oIF_pc   registered flush pulse and redirect pc
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rob_commit
   import rob_commit_pkg::*;
#(
   parameter int ROB_DEPTH = ROB_DEPTH_DEF,
   parameter int NICK_W    = NICK_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              iDP_en,
   input  logic [REG_W-1:0]  iDP_rd_regnm,
   input  op_t               iDP_op,
   input  logic [XLEN-1:0]   iDP_pc,
   input  logic              iDP_pd,
   input  logic [NICK_W-1:0] iDP_q1_nick,
   input  logic [NICK_W-1:0] iDP_q2_nick,
   output logic              oDP_full,
   output logic              oDP_q1_rdy,
   output logic [XLEN-1:0]   oDP_q1_dt,
   output logic              oDP_q2_rdy,
   output logic [XLEN-1:0]   oDP_q2_dt,
   output logic              oRF_nick_en,
   output logic [REG_W-1:0]  oRF_nick_regnm,
   output logic [NICK_W-1:0] oRF_nick,
   input  logic              iCDB_en,
   input  logic [NICK_W-1:0] iCDB_nick,
   input  logic [XLEN-1:0]   iCDB_dt,
   input  logic              iCDB_tk,
   input  logic [XLEN-1:0]   iCDB_tgt,
   output logic              oRF_en,
   output logic [REG_W-1:0]  oRF_rd_regnm,
   output logic [XLEN-1:0]   oRF_rd_dt,
   output logic [NICK_W-1:0] oRF_rd_nick,
   output logic              oLSB_st_en,
   output logic [NICK_W-1:0] oLSB_st_nick,
   output logic              oCLR,
   output logic [XLEN-1:0]   oIF_pc
);

   localparam int PTR_W = $clog2(ROB_DEPTH);
   localparam int CNT_W = $clog2(ROB_DEPTH + 1);

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [NICK_W-1:0] nick_t;

   localparam ptr_t  PTR_LAST = ptr_t'(ROB_DEPTH - 1);
   localparam cnt_t  CNT_FULL = cnt_t'(ROB_DEPTH);
   localparam nick_t NICK_MAX = nick_t'(ROB_DEPTH);

   // Entry storage, parallel arrays indexed by slot
   op_t             op_q    [ROB_DEPTH];
   op_t             op_d    [ROB_DEPTH];
   logic [REG_W-1:0] rd_q   [ROB_DEPTH];
   logic [REG_W-1:0] rd_d   [ROB_DEPTH];
   logic [XLEN-1:0] pc_q    [ROB_DEPTH];
   logic [XLEN-1:0] pc_d    [ROB_DEPTH];
   logic [XLEN-1:0] dt_q    [ROB_DEPTH];
   logic [XLEN-1:0] dt_d    [ROB_DEPTH];
   logic [XLEN-1:0] tgt_q   [ROB_DEPTH];
   logic [XLEN-1:0] tgt_d   [ROB_DEPTH];
   logic            pd_q    [ROB_DEPTH];
   logic            pd_d    [ROB_DEPTH];
   logic            tk_q    [ROB_DEPTH];
   logic            tk_d    [ROB_DEPTH];
   logic            ready_q [ROB_DEPTH];
   logic            ready_d [ROB_DEPTH];

   ptr_t head_q, head_d, tail_q, tail_d;
   cnt_t count_q, count_d;

   // Registered commit-side outputs
   logic              rf_en_q, rf_en_d;
   logic [REG_W-1:0]  rf_regnm_q, rf_regnm_d;
   logic [XLEN-1:0]   rf_dt_q, rf_dt_d;
   nick_t             rf_nick_q, rf_nick_d;
   logic              st_en_q, st_en_d;
   nick_t             st_nick_q, st_nick_d;
   logic              clr_q, clr_d;
   logic [XLEN-1:0]   if_pc_q, if_pc_d;

   logic  full, head_ready, commit, mispredict, flush, alloc, cdb_hit;
   op_t   h_op;
   nick_t head_nick;
   ptr_t  cdb_idx, q1_idx, q2_idx;

   assign full      = (count_q == CNT_FULL);
   assign h_op      = op_q[head_q];
   assign head_nick = nick_t'(head_q) + nick_t'(1);

   // Commit reads only registered ready bits, so a CDB result never retires
   // in the cycle it arrives.
   assign head_ready = (count_q != '0) && ready_q[head_q];
   assign commit     = rdy && head_ready && !clr_q;

   // jalr is fetched down the fall-through path, so any target other than
   // pc+4 is a redirect.
   assign mispredict = commit &&
      ((is_branch(h_op) && (tk_q[head_q] != pd_q[head_q])) ||
       (is_jalr(h_op) && (tgt_q[head_q] != pc_q[head_q] + 32'd4)));

   // Flush at the mispredict commit edge and again during the oCLR cycle,
   // so wrong-path dispatch and CDB traffic in either cycle is dropped.
   assign flush   = mispredict || (rdy && clr_q);
   assign alloc   = rdy && iDP_en && !full && !clr_q && !mispredict;
   assign cdb_hit = rdy && iCDB_en && !flush &&
                    (iCDB_nick != '0) && (iCDB_nick <= NICK_MAX);
   assign cdb_idx = ptr_t'(iCDB_nick - nick_t'(1));
   assign q1_idx  = ptr_t'(iDP_q1_nick - nick_t'(1));
   assign q2_idx  = ptr_t'(iDP_q2_nick - nick_t'(1));

   always_comb begin
      op_d    = op_q;
      rd_d    = rd_q;
      pc_d    = pc_q;
      dt_d    = dt_q;
      tgt_d   = tgt_q;
      pd_d    = pd_q;
      tk_d    = tk_q;
      ready_d = ready_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;

      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         for (int i = 0; i < ROB_DEPTH; i++) ready_d[i] = 1'b0;
      end else begin
         if (commit) begin
            ready_d[head_q] = 1'b0;
            head_d = (head_q == PTR_LAST) ? '0 : head_q + ptr_t'(1);
         end
         if (cdb_hit) begin
            dt_d[cdb_idx]    = iCDB_dt;
            tk_d[cdb_idx]    = iCDB_tk;
            tgt_d[cdb_idx]   = iCDB_tgt;
            ready_d[cdb_idx] = 1'b1;
         end
         if (alloc) begin
            op_d[tail_q]    = iDP_op;
            rd_d[tail_q]    = iDP_rd_regnm;
            pc_d[tail_q]    = iDP_pc;
            pd_d[tail_q]    = iDP_pd;
            ready_d[tail_q] = 1'b0;
            tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + ptr_t'(1);
         end
         case ({alloc, commit})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Commit-side output registers; pulses hold while rdy is low and are
   // masked at the ports.
   always_comb begin
      rf_en_d    = rf_en_q;
      rf_regnm_d = rf_regnm_q;
      rf_dt_d    = rf_dt_q;
      rf_nick_d  = rf_nick_q;
      st_en_d    = st_en_q;
      st_nick_d  = st_nick_q;
      clr_d      = clr_q;
      if_pc_d    = if_pc_q;
      if (rdy) begin
         rf_en_d = commit && !is_store(h_op) && !is_branch(h_op) &&
                   (rd_q[head_q] != '0);
         st_en_d = commit && is_store(h_op);
         clr_d   = mispredict;
         if (commit) begin
            rf_regnm_d = rd_q[head_q];
            rf_dt_d    = dt_q[head_q];
            rf_nick_d  = head_nick;
         end
         if (commit && is_store(h_op)) st_nick_d = head_nick;
         if (mispredict) if_pc_d = tgt_q[head_q];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ROB_DEPTH; i++) begin
            op_q[i]    <= OP_NOP;
            rd_q[i]    <= '0;
            pc_q[i]    <= '0;
            dt_q[i]    <= '0;
            tgt_q[i]   <= '0;
            pd_q[i]    <= 1'b0;
            tk_q[i]    <= 1'b0;
            ready_q[i] <= 1'b0;
         end
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         rf_en_q    <= 1'b0;
         rf_regnm_q <= '0;
         rf_dt_q    <= '0;
         rf_nick_q  <= '0;
         st_en_q    <= 1'b0;
         st_nick_q  <= '0;
         clr_q      <= 1'b0;
         if_pc_q    <= '0;
      end else begin
         op_q       <= op_d;
         rd_q       <= rd_d;
         pc_q       <= pc_d;
         dt_q       <= dt_d;
         tgt_q      <= tgt_d;
         pd_q       <= pd_d;
         tk_q       <= tk_d;
         ready_q    <= ready_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         rf_en_q    <= rf_en_d;
         rf_regnm_q <= rf_regnm_d;
         rf_dt_q    <= rf_dt_d;
         rf_nick_q  <= rf_nick_d;
         st_en_q    <= st_en_d;
         st_nick_q  <= st_nick_d;
         clr_q      <= clr_d;
         if_pc_q    <= if_pc_d;
      end
   end

   // Rename write: stores and branches have no destination.
   assign oRF_nick_en    = alloc && (iDP_rd_regnm != '0) &&
                           !is_store(iDP_op) && !is_branch(iDP_op);
   assign oRF_nick_regnm = oRF_nick_en ? iDP_rd_regnm : '0;
   assign oRF_nick       = oRF_nick_en ? nick_t'(tail_q) + nick_t'(1) : '0;

   assign oDP_full = full;

   // Operand bypass from registered results only; the RS snoops the CDB
   // for results arriving this cycle.
   assign oDP_q1_rdy = (iDP_q1_nick != '0) && (iDP_q1_nick <= NICK_MAX) &&
                       ready_q[q1_idx];
   assign oDP_q1_dt  = oDP_q1_rdy ? dt_q[q1_idx] : '0;
   assign oDP_q2_rdy = (iDP_q2_nick != '0) && (iDP_q2_nick <= NICK_MAX) &&
                       ready_q[q2_idx];
   assign oDP_q2_dt  = oDP_q2_rdy ? dt_q[q2_idx] : '0;

   assign oRF_en       = rf_en_q && rdy;
   assign oRF_rd_regnm = rf_regnm_q;
   assign oRF_rd_dt    = rf_dt_q;
   assign oRF_rd_nick  = rf_nick_q;
   assign oLSB_st_en   = st_en_q && rdy;
   assign oLSB_st_nick = st_nick_q;
   assign oCLR         = clr_q && rdy;
   assign oIF_pc       = if_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_rob_commit.sv
// ============================================================================
// Module  : tb_rob_commit
// Purpose : Directed self-checking bench for rob_commit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rob_commit;
   import rob_commit_pkg::*;

   logic        clk = 1'b0;
   logic        rst, rdy;
   logic        iDP_en;
   logic [4:0]  iDP_rd_regnm;
   op_t         iDP_op;
   logic [31:0] iDP_pc;
   logic        iDP_pd;
   logic [4:0]  iDP_q1_nick, iDP_q2_nick;
   logic        oDP_full, oDP_q1_rdy, oDP_q2_rdy;
   logic [31:0] oDP_q1_dt, oDP_q2_dt;
   logic        oRF_nick_en;
   logic [4:0]  oRF_nick_regnm, oRF_nick;
   logic        iCDB_en;
   logic [4:0]  iCDB_nick;
   logic [31:0] iCDB_dt;
   logic        iCDB_tk;
   logic [31:0] iCDB_tgt;
   logic        oRF_en;
   logic [4:0]  oRF_rd_regnm, oRF_rd_nick;
   logic [31:0] oRF_rd_dt;
   logic        oLSB_st_en;
   logic [4:0]  oLSB_st_nick;
   logic        oCLR;
   logic [31:0] oIF_pc;

   int n_cmp = 0;
   int n_err = 0;

   rob_commit #(.ROB_DEPTH(16), .NICK_W(5)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .iDP_en(iDP_en), .iDP_rd_regnm(iDP_rd_regnm), .iDP_op(iDP_op),
      .iDP_pc(iDP_pc), .iDP_pd(iDP_pd),
      .iDP_q1_nick(iDP_q1_nick), .iDP_q2_nick(iDP_q2_nick),
      .oDP_full(oDP_full), .oDP_q1_rdy(oDP_q1_rdy), .oDP_q1_dt(oDP_q1_dt),
      .oDP_q2_rdy(oDP_q2_rdy), .oDP_q2_dt(oDP_q2_dt),
      .oRF_nick_en(oRF_nick_en), .oRF_nick_regnm(oRF_nick_regnm),
      .oRF_nick(oRF_nick),
      .iCDB_en(iCDB_en), .iCDB_nick(iCDB_nick), .iCDB_dt(iCDB_dt),
      .iCDB_tk(iCDB_tk), .iCDB_tgt(iCDB_tgt),
      .oRF_en(oRF_en), .oRF_rd_regnm(oRF_rd_regnm), .oRF_rd_dt(oRF_rd_dt),
      .oRF_rd_nick(oRF_rd_nick),
      .oLSB_st_en(oLSB_st_en), .oLSB_st_nick(oLSB_st_nick),
      .oCLR(oCLR), .oIF_pc(oIF_pc)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      rdy = 1'b1; iDP_en = 1'b0; iDP_rd_regnm = '0; iDP_op = OP_NOP;
      iDP_pc = '0; iDP_pd = 1'b0; iDP_q1_nick = '0; iDP_q2_nick = '0;
      iCDB_en = 1'b0; iCDB_nick = '0; iCDB_dt = '0; iCDB_tk = 1'b0; iCDB_tgt = '0;
   endtask

   task automatic do_reset;
      idle();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic dp(input op_t op, input logic [4:0] rd, input logic [31:0] pc, input logic pd);
      iDP_en = 1'b1; iDP_op = op; iDP_rd_regnm = rd; iDP_pc = pc; iDP_pd = pd;
   endtask

   task automatic cdb(input logic [4:0] nick, input logic [31:0] dt, input logic tk, input logic [31:0] tgt);
      iCDB_en = 1'b1; iCDB_nick = nick; iCDB_dt = dt; iCDB_tk = tk; iCDB_tgt = tgt;
   endtask

   task automatic test_reset;
      do_reset();
      #1;
      n_cmp++; if (oDP_full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", oDP_full); end
      n_cmp++; if ({oRF_en, oLSB_st_en, oCLR, oRF_nick_en} !== 4'b0) begin n_err++; $display("FAIL reset_pulses got=%b exp=0000", {oRF_en, oLSB_st_en, oCLR, oRF_nick_en}); end
      n_cmp++; if (oIF_pc !== 32'h0) begin n_err++; $display("FAIL reset_ifpc got=%h exp=0", oIF_pc); end
      // mid-operation reset discards in-flight entries
      dp(OP_ADDI, 5'd1, 32'h0, 1'b0); tick(); tick();
      rst = 1'b1; tick(); rst = 1'b0; idle();
      dp(OP_ADDI, 5'd6, 32'h0, 1'b0); #1;
      n_cmp++; if (oRF_nick !== 5'd1) begin n_err++; $display("FAIL midrst_nick got=%0d exp=1", oRF_nick); end
      tick(); idle();
   endtask

   task automatic test_basic;
      do_reset();
      dp(OP_ADDI, 5'd5, 32'h0, 1'b0); #1;
      n_cmp++; if ({oRF_nick_en, oRF_nick_regnm, oRF_nick} !== {1'b1, 5'd5, 5'd1}) begin n_err++; $display("FAIL basic_rename got=%b/%0d/%0d exp=1/5/1", oRF_nick_en, oRF_nick_regnm, oRF_nick); end
      tick(); idle();
      cdb(5'd1, 32'd7, 1'b0, 32'h0); tick(); idle();
      n_cmp++; if (oRF_en !== 1'b0) begin n_err++; $display("FAIL basic_no_early_commit got=%b exp=0", oRF_en); end
      tick();
      n_cmp++; if ({oRF_en, oRF_rd_regnm, oRF_rd_dt, oRF_rd_nick} !== {1'b1, 5'd5, 32'd7, 5'd1}) begin n_err++; $display("FAIL basic_commit got=%b/%0d/%0d/%0d exp=1/5/7/1", oRF_en, oRF_rd_regnm, oRF_rd_dt, oRF_rd_nick); end
      tick();
      n_cmp++; if (oRF_en !== 1'b0) begin n_err++; $display("FAIL basic_pulse got=%b exp=0", oRF_en); end
   endtask

   task automatic test_full;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         dp(OP_ADDI, 5'(i + 1), 32'(i * 4), 1'b0); tick();
      end
      n_cmp++; if ({oDP_full, oRF_nick_en} !== 2'b10) begin n_err++; $display("FAIL full_flag got=%b exp=10", {oDP_full, oRF_nick_en}); end
      tick();
      n_cmp++; if (oDP_full !== 1'b1) begin n_err++; $display("FAIL full_hold got=%b exp=1", oDP_full); end
      idle();
      cdb(5'd1, 32'h11, 1'b0, 32'h0); tick(); idle(); tick();
      n_cmp++; if ({oRF_en, oRF_rd_nick, oRF_rd_regnm, oDP_full} !== {1'b1, 5'd1, 5'd1, 1'b0}) begin n_err++; $display("FAIL full_commit got=%b/%0d/%0d/%b exp=1/1/1/0", oRF_en, oRF_rd_nick, oRF_rd_regnm, oDP_full); end
      iDP_q1_nick = 5'd2; dp(OP_ADDI, 5'd9, 32'h0, 1'b0); #1;
      n_cmp++; if ({oRF_nick_en, oRF_nick} !== {1'b1, 5'd1}) begin n_err++; $display("FAIL full_wrap_nick got=%b/%0d exp=1/1", oRF_nick_en, oRF_nick); end
      n_cmp++; if (oDP_q1_rdy !== 1'b0) begin n_err++; $display("FAIL full_q1_notready got=%b exp=0", oDP_q1_rdy); end
      tick(); idle();
   endtask

   task automatic test_out_of_order;
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         dp(OP_ADDI, 5'(i), 32'h0, 1'b0); tick();
      end
      idle();
      cdb(5'd3, 32'd30, 1'b0, 32'h0); tick();
      cdb(5'd2, 32'd20, 1'b0, 32'h0); tick();
      cdb(5'd1, 32'd10, 1'b0, 32'h0); tick(); idle();
      n_cmp++; if (oRF_en !== 1'b0) begin n_err++; $display("FAIL ooo_none_yet got=%b exp=0", oRF_en); end
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_cmp++; if ({oRF_en, oRF_rd_nick, oRF_rd_dt} !== {1'b1, 5'(i), 32'(i * 10)}) begin n_err++; $display("FAIL ooo_commit%0d got=%b/%0d/%0d exp=1/%0d/%0d", i, oRF_en, oRF_rd_nick, oRF_rd_dt, i, i * 10); end
      end
      tick();
      n_cmp++; if (oRF_en !== 1'b0) begin n_err++; $display("FAIL ooo_drained got=%b exp=0", oRF_en); end
   endtask

   task automatic test_branch;
      do_reset();
      dp(OP_BEQ, 5'd0, 32'h40, 1'b0); #1;
      n_cmp++; if (oRF_nick_en !== 1'b0) begin n_err++; $display("FAIL br_no_rename got=%b exp=0", oRF_nick_en); end
      tick();
      dp(OP_ADDI, 5'd8, 32'h44, 1'b0); tick(); idle();
      cdb(5'd1, 32'h0, 1'b1, 32'h100); tick(); idle(); tick();
      n_cmp++; if ({oCLR, oIF_pc, oRF_en} !== {1'b1, 32'h100, 1'b0}) begin n_err++; $display("FAIL br_clr got=%b/%h/%b exp=1/00000100/0", oCLR, oIF_pc, oRF_en); end
      dp(OP_ADDI, 5'd3, 32'h0, 1'b0); #1;
      n_cmp++; if (oRF_nick_en !== 1'b0) begin n_err++; $display("FAIL br_drop_dp got=%b exp=0", oRF_nick_en); end
      tick();
      n_cmp++; if ({oCLR, oDP_full, oRF_nick_en, oRF_nick} !== {1'b0, 1'b0, 1'b1, 5'd1}) begin n_err++; $display("FAIL br_after got=%b/%b/%b/%0d exp=0/0/1/1", oCLR, oDP_full, oRF_nick_en, oRF_nick); end
      tick(); idle();
   endtask

   task automatic test_jalr;
      do_reset();
      dp(OP_JALR, 5'd1, 32'h20, 1'b0); tick(); idle();
      cdb(5'd1, 32'h24, 1'b1, 32'h80); tick(); idle(); tick();
      n_cmp++; if ({oCLR, oIF_pc, oRF_en, oRF_rd_dt} !== {1'b1, 32'h80, 1'b1, 32'h24}) begin n_err++; $display("FAIL jalr got=%b/%h/%b/%h exp=1/00000080/1/00000024", oCLR, oIF_pc, oRF_en, oRF_rd_dt); end
      tick();
   endtask

   task automatic test_store;
      do_reset();
      dp(OP_SW, 5'd5, 32'h0, 1'b0); #1;
      n_cmp++; if (oRF_nick_en !== 1'b0) begin n_err++; $display("FAIL st_no_rename got=%b exp=0", oRF_nick_en); end
      tick(); idle();
      cdb(5'd1, 32'h0, 1'b0, 32'h0); tick(); idle(); tick();
      n_cmp++; if ({oLSB_st_en, oLSB_st_nick, oRF_en} !== {1'b1, 5'd1, 1'b0}) begin n_err++; $display("FAIL st_commit got=%b/%0d/%b exp=1/1/0", oLSB_st_en, oLSB_st_nick, oRF_en); end
      tick();
   endtask

   task automatic test_rdy_bypass;
      do_reset();
      dp(OP_ADDI, 5'd3, 32'h0, 1'b0); tick();
      dp(OP_ADDI, 5'd4, 32'h4, 1'b0); tick(); idle();
      cdb(5'd2, 32'd9, 1'b0, 32'h0); tick(); idle();
      iDP_q1_nick = 5'd2; iDP_q2_nick = 5'd1; #1;
      n_cmp++; if ({oDP_q1_rdy, oDP_q1_dt, oDP_q2_rdy} !== {1'b1, 32'd9, 1'b0}) begin n_err++; $display("FAIL bypass got=%b/%0d/%b exp=1/9/0", oDP_q1_rdy, oDP_q1_dt, oDP_q2_rdy); end
      cdb(5'd1, 32'd5, 1'b0, 32'h0); tick(); idle();
      rdy = 1'b0; dp(OP_ADDI, 5'd7, 32'h0, 1'b0); #1;
      n_cmp++; if (oRF_nick_en !== 1'b0) begin n_err++; $display("FAIL stall_rename got=%b exp=0", oRF_nick_en); end
      tick();
      n_cmp++; if (oRF_en !== 1'b0) begin n_err++; $display("FAIL stall_commit1 got=%b exp=0", oRF_en); end
      tick();
      n_cmp++; if (oRF_en !== 1'b0) begin n_err++; $display("FAIL stall_commit2 got=%b exp=0", oRF_en); end
      idle(); tick();
      n_cmp++; if ({oRF_en, oRF_rd_nick, oRF_rd_dt, oRF_rd_regnm} !== {1'b1, 5'd1, 32'd5, 5'd3}) begin n_err++; $display("FAIL resume1 got=%b/%0d/%0d/%0d exp=1/1/5/3", oRF_en, oRF_rd_nick, oRF_rd_dt, oRF_rd_regnm); end
      tick();
      n_cmp++; if ({oRF_en, oRF_rd_nick, oRF_rd_dt, oRF_rd_regnm} !== {1'b1, 5'd2, 32'd9, 5'd4}) begin n_err++; $display("FAIL resume2 got=%b/%0d/%0d/%0d exp=1/2/9/4", oRF_en, oRF_rd_nick, oRF_rd_dt, oRF_rd_regnm); end
      tick();
   endtask

   initial begin
      idle();
      rst = 1'b1;
      test_reset();
      test_basic();
      test_full();
      test_out_of_order();
      test_branch();
      test_jalr();
      test_store();
      test_rdy_bypass();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
